// File: rtl/au_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states, default width and
// the iteration-counter width helper.
package au_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DIV_WIDTH = 32;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/div_32b_seq_if.sv
// Start/busy/done handshake and hi/lo result bus of the sequential divider.
interface div_32b_seq_if
    import au_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;
    logic             div_zero;

    modport master (
        output start, a, b,
        input  busy, done, hi, lo, zero, div_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, hi, lo, zero, div_zero
    );

endinterface

// File: rtl/div_32b_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits, using a WIDTH+1 bit compare.
module div_step
    import au_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_sh;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sh   = {i_rem, i_quo[WIDTH-1]};
        w_diff = w_sh - {1'b0, i_dvs};
        if (!w_diff[WIDTH]) begin
            o_rem = w_diff[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_sh[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_32b_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock;
// result returned as hi = remainder, lo = quotient.
module div_32b_seq
    import au_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    div_32b_seq_if.slave bus
);

    localparam int unsigned CW = cnt_width(WIDTH);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_zero;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_b_zero;
    logic             w_last;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    assign w_b_zero = (bus.b == '0);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = w_b_zero ? DONE : CALC;
            CALC:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_zero     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_b_zero) begin
                            r_hi       <= '0;
                            r_lo       <= '0;
                            r_zero     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_rem <= '0;
                            r_quo <= bus.a;
                            r_dvs <= bus.b;
                            r_cnt <= '0;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    // Result publishes straight from the final step, so DONE sees it.
                    if (w_last) begin
                        r_hi       <= w_rem_nxt;
                        r_lo       <= w_quo_nxt;
                        r_zero     <= (w_quo_nxt == '0);
                        r_div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.zero     = r_zero;
    assign bus.div_zero = r_div_zero;

endmodule

// File: doc/div_32b_seq.md
# div_32b_seq

Multi-cycle unsigned restoring divider that produces one quotient bit per clock. It sits beside the 32-bit arithmetic unit as the sequential divide path. It returns quotient and remainder in the team's hi/lo convention: hi = remainder, lo = quotient. A start/busy/done handshake lets a controller issue one division and collect the result without stalling the add/sub path.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2)
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- start  input  1  request a division; sampled only in IDLE
- a  input  WIDTH  dividend; captured on the accepting edge
- b  input  WIDTH  divisor; captured on the accepting edge
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; hi/lo/zero/div_zero are valid
- hi  output  WIDTH  remainder of the last completed division
- lo  output  WIDTH  quotient of the last completed division
- zero  output  1  lo == 0 for the last completed division
- div_zero  output  1  last completed division had b == 0

## Operation
- States:
  - IDLE: accepts a request when start = 1.
  - CALC: performs the iterations.
  - DONE: lasts one cycle, asserts done, then returns to IDLE unconditionally.
- Accept in IDLE with start = 1:
  - If b == 0: go to DONE. Load hi = 0, lo = 0, zero = 1, div_zero = 1.
  - Otherwise: load rem = 0, quo = a, dvs = b, cnt = 0, and go to CALC.
- Each CALC iteration:
  - sh = {rem, quo[WIDTH-1]} (WIDTH+1 bits).
  - diff = sh − {1'b0, dvs}.
  - If diff[WIDTH] == 0: rem = diff[WIDTH-1:0] and quo = {quo[WIDTH-2:0], 1}.
  - Otherwise: rem = sh[WIDTH-1:0] and quo = {quo[WIDTH-2:0], 0}.
  - cnt increments.
- The compare is WIDTH+1 bits wide, so a remainder ≥ 2^(WIDTH-1) never overflows.
- On the iteration where cnt == WIDTH-1: go to DONE. Load hi = final rem, lo = final quo, zero = (final quo == 0), div_zero = 0.
- hi, lo, zero and div_zero hold their values until the next completion. done is combinational from state == DONE.
- start while busy (CALC or DONE): ignored. No queuing, and no change to the operation in flight.
- a/b changing after acceptance: no effect, because the operands are captured.

## Timing
- Reset values (rst_n low at a rising edge): state IDLE, busy 0, done 0, hi 0, lo 0, zero 0, div_zero 0, internal rem/quo/dvs/cnt 0.
- Normal latency, with start accepted in cycle 0:
  - CALC in cycles 1..WIDTH.
  - done = 1 in cycle WIDTH+1 (cycle 33 for WIDTH = 32).
  - busy = 1 in cycles 1..WIDTH+1.
- Divide by zero: done = 1 in cycle 1, busy = 1 only in cycle 1.
- Throughput: the earliest next accept is in cycle WIDTH+2 (IDLE). start asserted during DONE is dropped.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. No done pulse, and the partial result is discarded.
- rst_n low together with start: reset wins and the request is lost.

## Structure
- Shared package au_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE);
  - the default width constant (32);
  - the counter-width expression $clog2(WIDTH).
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: rem, quo, dvs.
  - Outputs: next rem, next quo.
  - Instantiated once; the top level holds the FSM, registers and counter.

## Test plan
- a = 100, b = 7, start in cycle 0 -> done only in cycle 33; lo = 14, hi = 2, zero = 0, div_zero = 0; busy high in cycles 1–33.
- a = 0xFFFFFFFF, b = 1 -> lo = 0xFFFFFFFF, hi = 0; a = 0xFFFFFFFF, b = 0xFFFFFFFF -> lo = 1, hi = 0.
- a = 5, b = 0 -> done in cycle 1; hi = 0, lo = 0, zero = 1, div_zero = 1; busy low again in cycle 2.
- a = 3, b = 10 -> lo = 0, hi = 3, zero = 1, div_zero = 0. Then a = 0x80000000, b = 0xFFFFFFFF -> lo = 0, hi = 0x80000000 (checks the WIDTH+1 compare).
- Accept a = 100, b = 7, then pulse start with a = 9, b = 3 in cycles 5 and 33 -> the result is still 14 r 2 with exactly one done. A new start in cycle 34 gives done in cycle 67 with lo = 3, hi = 0.
- Accept a = 100, b = 7, then drive rst_n low in cycle 10 -> cycle 11 shows busy 0 and hi/lo/zero/div_zero 0; no done appears through cycle 40.
